mac_accumulator: RTL

MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

---
 rtl/mac_accumulator_pkg.sv | 14 +
 rtl/mac_sat_add.sv | 26 ++
 rtl/mac_accumulator.sv | 97 +++++++++
 3 files changed

// File: rtl/mac_accumulator_pkg.sv
// Shared types and constants for the MAC accumulator slice.
// Optional build macro: MAC_ACCUMULATOR_SATURATE_EN (clamp instead of wrap).
package mac_accumulator_pkg;

    localparam int PROD_W            = 8;
    localparam int DEFAULT_ACC_W     = 12;
    localparam int DEFAULT_MAX_TERMS = 16;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

endpackage

// File: rtl/mac_sat_add.sv
// Combinational accumulator + product adder with carry-out.
// MAC_ACCUMULATOR_SATURATE_EN selects clamp-to-max on carry; otherwise the sum wraps.
module mac_sat_add
    import mac_accumulator_pkg::*;
#(
    parameter int ACC_W = DEFAULT_ACC_W
) (
    input  logic [ACC_W-1:0]  i_acc,
    input  logic [PROD_W-1:0] i_prod,
    output logic [ACC_W-1:0]  o_sum,
    output logic              o_carry
);

    logic [ACC_W:0] w_full;

    assign w_full  = {1'b0, i_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, i_prod};
    assign o_carry = w_full[ACC_W];

`ifdef MAC_ACCUMULATOR_SATURATE_EN
    // Once clamped, any further add carries again, so the clamp persists.
    assign o_sum = o_carry ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];
`else
    assign o_sum = w_full[ACC_W-1:0];
`endif

endmodule

// File: rtl/mac_accumulator.sv
// Accumulates 8-bit products into an ACC_W-bit sum, then holds the result until consumed.
// Build macro MAC_ACCUMULATOR_SATURATE_EN selects saturating accumulation (default: wrap).
module mac_accumulator
    import mac_accumulator_pkg::*;
#(
    parameter int ACC_W     = DEFAULT_ACC_W,
    parameter int MAX_TERMS = DEFAULT_MAX_TERMS,
    localparam int CNT_W    = $clog2(MAX_TERMS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              overflow,
    output state_t            dbg_state
);

    // Handshake: a product transfers on a rising edge where in_valid && in_ready;
    // the result transfers on an edge where out_valid && out_ready. in_ready and
    // out_valid are registered and mutually exclusive (ACCUM vs DONE).
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_TERMS - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    state_t           r_state;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic             r_in_ready;
    logic             r_out_valid;

    logic [ACC_W-1:0] w_sum;
    logic             w_carry;
    logic             w_accept;
    logic             w_final;

    mac_sat_add #(
        .ACC_W (ACC_W)
    ) u_add (
        .i_acc   (r_acc),
        .i_prod  (in_prod),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    assign w_accept = in_valid & r_in_ready;
    assign w_final  = in_last | (r_count == LAST_CNT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ACCUM;
            r_acc       <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_accept) begin
                        r_acc   <= w_sum;
                        r_count <= r_count + ONE_CNT;
                        if (w_carry) r_overflow <= 1'b1;
                        if (w_final) begin
                            r_state     <= DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= ACCUM;
                        r_acc       <= '0;
                        r_count     <= '0;
                        r_overflow  <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_acc;
    assign out_count = r_count;
    assign overflow  = r_overflow;
    assign dbg_state = r_state;

endmodule
